// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame buffer write arbiter.
package fb_arb_pkg;
    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_FILL = 1'b1
    } gnt_src_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// CPU write buffer: synchronous FIFO with first-word-fall-through read data.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 31
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign rdata   = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    // a pop frees the slot in the same cycle, so a full FIFO still takes the push
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge pclk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Merges buffered CPU pixel writes and fill-engine beats onto the frame buffer write port.
// Build option FB_FILL_EN compiles in the fill engine and round-robin arbitration.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          cpu_wr,
    input  logic [ADDR_W-1:0]             cpu_waddr,
    input  logic [DATA_W-1:0]             cpu_data,
    input  logic                          fill_start,
    input  logic [ADDR_W-1:0]             fill_base,
    input  logic [ADDR_W-1:0]             fill_len,
    input  logic [DATA_W-1:0]             fill_color,
    input  logic                          ovf_clr,
    input  logic                          fb_ready,
    output logic                          fb_wr,
    output logic [ADDR_W-1:0]             fb_waddr,
    output logic [DATA_W-1:0]             fb_wdata,
    output logic                          fill_busy,
    output logic                          fill_done,
    output logic                          cpu_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] fifo_rdata;
    logic [ENT_W-1:0] cpu_ent;
    logic [ENT_W-1:0] fill_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             cpu_cand;
    logic             load_en;
    logic             gnt_cpu;
    logic             gnt_fill;
    gnt_src_t         out_src;

    assign load_en   = !fb_wr || fb_ready;
    // an empty FIFO is bypassed so a lone CPU write reaches the port one cycle later
    assign cpu_cand  = !fifo_empty || cpu_wr;
    assign cpu_ent   = fifo_empty ? {cpu_waddr, cpu_data} : fifo_rdata;
    assign fifo_pop  = gnt_cpu && !fifo_empty;
    assign fifo_push = cpu_wr && !(gnt_cpu && fifo_empty);

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .pclk    (pclk),
        .presetn (presetn),
        .push    (fifo_push),
        .wdata   ({cpu_waddr, cpu_data}),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cpu_ovf <= 1'b0;
        end else if (cpu_wr && fifo_full && !fifo_pop) begin
            cpu_ovf <= 1'b1;
        end else if (ovf_clr) begin
            cpu_ovf <= 1'b0;
        end
    end

`ifdef FB_FILL_EN
    fill_state_t       state_q;
    fill_state_t       state_d;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] remain;
    logic [DATA_W-1:0] color_q;
    gnt_src_t          prio_q;
    logic              fill_cand;
    logic              done_d;
    logic              fill_load;

    assign fill_cand = (state_q == RUN);
    assign fill_load = (state_q == IDLE) && fill_start && (fill_len != '0);
    assign fill_ent  = {addr_cnt, color_q};
    assign fill_busy = (state_q != IDLE);

    always_comb begin
        gnt_cpu  = 1'b0;
        gnt_fill = 1'b0;
        if (load_en) begin
            if (cpu_cand && fill_cand) begin
                gnt_cpu  = (prio_q == GNT_CPU);
                gnt_fill = (prio_q == GNT_FILL);
            end else begin
                gnt_cpu  = cpu_cand;
                gnt_fill = fill_cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_start && fill_len != '0) state_d = RUN;
                else if (fill_start)              done_d  = 1'b1;
            end
            RUN: begin
                if (gnt_fill && remain == ADDR_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (fb_wr && fb_ready && out_src == GNT_FILL) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            fill_done <= 1'b0;
            addr_cnt  <= '0;
            remain    <= '0;
            color_q   <= '0;
            prio_q    <= GNT_CPU;
        end else begin
            state_q   <= state_d;
            fill_done <= done_d;
            if (fill_load) begin
                addr_cnt <= fill_base;
                remain   <= fill_len;
                color_q  <= fill_color;
            end else if (gnt_fill) begin
                addr_cnt <= addr_cnt + 1'b1;
                remain   <= remain - 1'b1;
            end
            if (gnt_cpu)       prio_q <= GNT_FILL;
            else if (gnt_fill) prio_q <= GNT_CPU;
        end
    end
`else
    logic unused_fill;

    assign gnt_cpu     = load_en && cpu_cand;
    assign gnt_fill    = 1'b0;
    assign fill_ent    = '0;
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
    assign unused_fill = ^{fill_start, fill_base, fill_len, fill_color, out_src};
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            fb_wr    <= 1'b0;
            fb_waddr <= '0;
            fb_wdata <= '0;
            out_src  <= GNT_CPU;
        end else if (load_en) begin
            fb_wr <= gnt_cpu || gnt_fill;
            if (gnt_fill) begin
                {fb_waddr, fb_wdata} <= fill_ent;
                out_src              <= GNT_FILL;
            end else if (gnt_cpu) begin
                {fb_waddr, fb_wdata} <= cpu_ent;
                out_src              <= GNT_CPU;
            end
        end
    end
endmodule
